// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared state encoding, saturation limits and helpers for the echo stage
package echo_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_MIX,
    S_WRITE
  } echo_state_t;

  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;
  localparam int GAIN_SHIFT = 3;

  // Clamp a 33-bit sum back into 32 bits; overflow shows as the top two bits disagreeing.
  function automatic logic signed [31:0] sat32(input logic signed [32:0] sum);
    logic signed [31:0] res;
    res = sum[31:0];
    if (sum[32] != sum[31])
      res = sum[32] ? SAT_MIN : SAT_MAX;
    return res;
  endfunction

endpackage

// File: rtl/echo_ram.sv
// rtl/echo_ram.sv - simple dual-port delay buffer, registered read, no reset
module echo_ram
  import echo_pkg::*;
#(
  parameter int DEPTH = 8192,
  parameter int WIDTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/echo_effect.sv
// rtl/echo_effect.sv - stereo feedback echo: delayed buffer read, scaled mix with saturation, write-back
module echo_effect
  import echo_pkg::*;
#(
  parameter int DEPTH = 8192,
  parameter int STORE_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic signed [31:0]  in_L,
  input  logic signed [31:0]  in_R,
  input  logic [ADDR_W-1:0]   delay_len,
  input  logic [2:0]          gain,
  output logic signed [31:0]  out_L,
  output logic signed [31:0]  out_R,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  echo_state_t state, state_next;

  logic [ADDR_W-1:0]    clr_addr;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    dly_q;
  logic [ADDR_W-1:0]    rd_addr;
  logic signed [31:0]   in_l_q, in_r_q;
  logic                 en_q;
  logic [2:0]           gain_q;
  logic signed [31:0]   mix_l, mix_r;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_waddr;
  logic [2*STORE_W-1:0] ram_wdata, ram_rdata;

  // Stored word is the top of a 32-bit sample; widen to 36 bits so gain*sample cannot overflow.
  function automatic logic signed [31:0] wet_of(input logic [STORE_W-1:0] stored,
                                                input logic [2:0] g);
    logic signed [35:0] del36, g36, prod;
    del36 = 36'($signed(stored)) <<< (32 - STORE_W);
    g36   = $signed({33'd0, g});
    prod  = (del36 * g36) >>> GAIN_SHIFT;
    return 32'(prod);
  endfunction

  function automatic logic signed [31:0] mix_of(input logic signed [31:0] x,
                                                input logic [STORE_W-1:0] stored,
                                                input logic [2:0] g,
                                                input logic en);
    logic signed [31:0] wet;
    wet = wet_of(stored, g);
    return en ? sat32({x[31], x} + {wet[31], wet}) : x;
  endfunction

  assign rd_addr = wr_ptr - dly_q;
  assign busy    = (state != S_IDLE);

  always_comb begin
    mix_l = mix_of(in_l_q, ram_rdata[2*STORE_W-1 -: STORE_W], gain_q, en_q);
    mix_r = mix_of(in_r_q, ram_rdata[STORE_W-1:0], gain_q, en_q);
  end

  // The output registers hold the mix during WRITE, so they double as the write-back data.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_ptr;
    ram_wdata = {out_L[31 -: STORE_W], out_R[31 -: STORE_W]};
    if (state == S_CLEAR) begin
      ram_we    = !reset;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end else if (state == S_WRITE) begin
      ram_we    = !reset;
    end
  end

  echo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2*STORE_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      state <= S_CLEAR;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = S_IDLE;
      S_IDLE:  if (sample_valid) state_next = S_READ;
      S_READ:  state_next = S_MIX;
      S_MIX:   state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_L     <= '0;
      out_R     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      wr_ptr    <= '0;
      clr_addr  <= '0;
      dly_q     <= ADDR_W'(1);
      in_l_q    <= '0;
      in_r_q    <= '0;
      en_q      <= 1'b0;
      gain_q    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (sample_valid) begin
            out_L     <= in_L;
            out_R     <= in_R;
            out_valid <= 1'b1;
          end
        end
        S_IDLE: begin
          if (sample_valid) begin
            in_l_q <= in_L;
            in_r_q <= in_R;
            en_q   <= enable;
            gain_q <= gain;
            dly_q  <= (delay_len == '0) ? ADDR_W'(1) : delay_len;
          end
        end
        S_READ: begin
          if (sample_valid) overrun <= 1'b1;
        end
        S_MIX: begin
          if (sample_valid) overrun <= 1'b1;
          out_L     <= mix_l;
          out_R     <= mix_r;
          out_valid <= 1'b1;
        end
        S_WRITE: begin
          if (sample_valid) overrun <= 1'b1;
          wr_ptr <= wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_effect.sv
// tb/tb_echo_effect.sv - directed self-checking bench for echo_effect
module tb_echo_effect;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [31:0] in_L = '0;
  logic signed [31:0] in_R = '0;
  logic [ADDR_W-1:0]  delay_len = 8'd1;
  logic [2:0]         gain = 3'd0;
  logic signed [31:0] out_L, out_R;
  logic               out_valid, busy, overrun;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  echo_effect #(.DEPTH(DEPTH), .STORE_W(16)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .in_L         (in_L),
    .in_R         (in_R),
    .delay_len    (delay_len),
    .gain         (gain),
    .out_L        (out_L),
    .out_R        (out_R),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  // One strobe in IDLE; returns outputs seen with out_valid and cycles from strobe to out_valid.
  task automatic send_sample(input logic [31:0] l, input logic [31:0] r, input bit scramble,
                             output logic [31:0] ol, output logic [31:0] orr, output int lat);
    in_L = l;
    in_R = r;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    if (scramble) begin
      enable    = ~enable;
      gain      = ~gain;
      delay_len = delay_len + 8'd3;
    end
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    ol  = out_L;
    orr = out_R;
    tick();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < DEPTH + 50) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    sample_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (out_L !== 32'h0) begin errors++; $display("FAIL reset_out_L got=%h exp=00000000", out_L); end
    checks++; if (out_R !== 32'h0) begin errors++; $display("FAIL reset_out_R got=%h exp=00000000", out_R); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    in_L = 32'h1234_0000;
    in_R = 32'hABCD_0000;
    n = 0;
    while (busy && n < DEPTH + 50) begin
      if (n == 6 || n == 11 || n == 16) begin
        checks++;
        if (out_valid !== 1'b1 || out_L !== 32'h1234_0000 || out_R !== 32'hABCD_0000) begin
          errors++;
          $display("FAIL clear_dry n=%0d got valid=%b L=%h R=%h exp valid=1 L=12340000 R=abcd0000",
                   n, out_valid, out_L, out_R);
        end
      end
      sample_valid = (n == 5 || n == 10 || n == 15);
      tick();
      n++;
    end
    sample_valid = 1'b0;
    checks++; if (n != DEPTH) begin errors++; $display("FAIL clear_length got=%0d exp=%0d", n, DEPTH); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clear_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_impulse;
    logic [31:0] ol, orr, el, er;
    int lat;
    enable = 1'b1;
    gain = 3'd4;
    delay_len = 8'd4;
    for (int i = 0; i < 9; i++) begin
      send_sample((i == 0) ? 32'h4000_0000 : 32'h0, (i == 0) ? 32'hC000_0000 : 32'h0, 1'b0, ol, orr, lat);
      el = (i == 0) ? 32'h4000_0000 : (i == 4) ? 32'h2000_0000 : (i == 8) ? 32'h1000_0000 : 32'h0;
      er = (i == 0) ? 32'hC000_0000 : (i == 4) ? 32'hE000_0000 : (i == 8) ? 32'hF000_0000 : 32'h0;
      checks++; if (ol !== el) begin errors++; $display("FAIL impulse_L[%0d] got=%h exp=%h", i, ol, el); end
      checks++; if (orr !== er) begin errors++; $display("FAIL impulse_R[%0d] got=%h exp=%h", i, orr, er); end
      checks++; if (lat != 3) begin errors++; $display("FAIL impulse_latency[%0d] got=%0d exp=3", i, lat); end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] ol, orr;
    int lat;
    enable = 1'b1;
    delay_len = 8'd1;
    gain = 3'd0;
    send_sample(32'h0, 32'h0, 1'b0, ol, orr, lat);
    checks++; if (ol !== 32'h0 || orr !== 32'h0) begin errors++; $display("FAIL sat_prime got L=%h R=%h exp 0/0", ol, orr); end
    gain = 3'd7;
    send_sample(32'h7000_0000, 32'h9000_0000, 1'b0, ol, orr, lat);
    checks++; if (ol !== 32'h7000_0000) begin errors++; $display("FAIL sat_first_L got=%h exp=70000000", ol); end
    checks++; if (orr !== 32'h9000_0000) begin errors++; $display("FAIL sat_first_R got=%h exp=90000000", orr); end
    send_sample(32'h7000_0000, 32'h9000_0000, 1'b0, ol, orr, lat);
    checks++; if (ol !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos got=%h exp=7fffffff", ol); end
    checks++; if (orr !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg got=%h exp=80000000", orr); end
    delay_len = 8'd0;
    gain = 3'd1;
    send_sample(32'h0, 32'h0, 1'b0, ol, orr, lat);
    checks++; if (ol !== 32'h0FFF_E000) begin errors++; $display("FAIL delay0_L got=%h exp=0fffe000", ol); end
    checks++; if (orr !== 32'hF000_0000) begin errors++; $display("FAIL delay0_R got=%h exp=f0000000", orr); end
  endtask

  task automatic test_bypass_history;
    logic [31:0] ol, orr;
    int lat;
    enable = 1'b0;
    gain = 3'd4;
    delay_len = 8'd2;
    send_sample(32'h1234_5678, 32'h8765_4321, 1'b0, ol, orr, lat);
    checks++; if (ol !== 32'h1234_5678 || orr !== 32'h8765_4321) begin
      errors++; $display("FAIL bypass_A got L=%h R=%h exp 12345678/87654321", ol, orr); end
    send_sample(32'hF000_0001, 32'h0000_FFFF, 1'b0, ol, orr, lat);
    checks++; if (ol !== 32'hF000_0001 || orr !== 32'h0000_FFFF) begin
      errors++; $display("FAIL bypass_B got L=%h R=%h exp f0000001/0000ffff", ol, orr); end
    enable = 1'b1;
    send_sample(32'h0, 32'h0, 1'b1, ol, orr, lat);
    checks++; if (ol !== 32'h091A_0000) begin errors++; $display("FAIL history_L got=%h exp=091a0000", ol); end
    checks++; if (orr !== 32'hC3B2_8000) begin errors++; $display("FAIL history_R got=%h exp=c3b28000", orr); end
    checks++; if (lat != 3) begin errors++; $display("FAIL history_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_overrun;
    int nv;
    enable = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
    in_L = 32'h0101_0000;
    in_R = 32'h0202_0000;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) nv++;
      tick();
    end
    checks++; if (nv != 1) begin errors++; $display("FAIL overrun_valid_count got=%0d exp=1", nv); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    checks++; if (out_L !== 32'h0101_0000) begin errors++; $display("FAIL overrun_out_L got=%h exp=01010000", out_L); end
  endtask

  task automatic test_mid_reset;
    int n;
    enable = 1'b1;
    gain = 3'd4;
    delay_len = 8'd4;
    in_L = 32'h5555_0000;
    in_R = 32'h3333_0000;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (out_L !== 32'h0 || out_R !== 32'h0) begin errors++; $display("FAIL midrst_out got L=%h R=%h exp 0/0", out_L, out_R); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
    wait_clear(n);
    checks++; if (n != DEPTH) begin errors++; $display("FAIL midrst_clear_length got=%0d exp=%0d", n, DEPTH); end
    test_impulse();
  endtask

  task automatic test_wrap;
    logic [31:0] ol, orr, el, er;
    int lat, n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_clear(n);
    enable = 1'b1;
    gain = 3'd4;
    delay_len = 8'(DEPTH - 1);
    for (int k = 0; k < DEPTH + 10; k++) begin
      send_sample((k == 5) ? 32'h4000_0000 : 32'h0, (k == 5) ? 32'h8000_0000 : 32'h0, 1'b0, ol, orr, lat);
      el = (k == 5) ? 32'h4000_0000 : (k == DEPTH + 4) ? 32'h2000_0000 : 32'h0;
      er = (k == 5) ? 32'h8000_0000 : (k == DEPTH + 4) ? 32'hC000_0000 : 32'h0;
      checks++;
      if (ol !== el || orr !== er || lat != 3) begin
        errors++;
        $display("FAIL wrap[%0d] got L=%h R=%h lat=%0d exp L=%h R=%h lat=3", k, ol, orr, lat, el, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_bypass_history();
    test_overrun();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
